// File: rtl/rom_pkg.sv
// Shared definitions for the ROM read path: default geometry and sequencer states.
package rom_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 10;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_SEND = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/rom_sequencer_if.sv
// Output stream of the ROM sequencer: valid/ready with a last-beat flag.
interface rom_sequencer_if
    import rom_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rom_sequencer.sv
// Sweeps ROM addresses 0..DEPTH-1, waits WAIT_CYC settle cycles per address,
// registers each word and streams it out with a last flag.
module rom_sequencer
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = 10,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    rom_sequencer_if.master   out
);

    localparam int unsigned       CNT_W     = $clog2(WAIT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    // Next-state logic: abort outranks every in-run action, including a handshake.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        data_d  = rom_data;
                        valid_d = 1'b1;
                        last_d  = (addr_q == LAST_ADDR);
                        state_d = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (valid_q && out.out_ready) begin
                        valid_d = 1'b0;
                        if (last_q) begin
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            cnt_d   = CNT_LOAD;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign rom_addr      = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign out.out_data  = data_q;
    assign out.out_valid = valid_q;
    assign out.out_last  = last_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: nominal, slow-settle and single-word instances.
module tb_rom_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: DEPTH=10, WAIT_CYC=1, immediate ROM
    logic       start0 = 1'b0, abort0 = 1'b0, busy0, done0;
    logic [3:0] rom_addr0;
    logic [9:0] rom_data0;
    rom_sequencer_if #(.DATA_W(10)) if0 ();
    assign rom_data0 = 10'h3C0 | {6'b0, rom_addr0};
    rom_sequencer #(.ADDR_W(4), .DATA_W(10), .DEPTH(10), .WAIT_CYC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .busy(busy0),
        .done(done0), .rom_addr(rom_addr0), .rom_data(rom_data0), .out(if0));

    // Instance 1: DEPTH=10, WAIT_CYC=3, ROM output lags the address by two cycles
    logic       start1 = 1'b0, abort1 = 1'b0, busy1, done1;
    logic [3:0] rom_addr1, lag_a, lag_b;
    logic [9:0] rom_data1;
    rom_sequencer_if #(.DATA_W(10)) if1 ();
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag_a <= 4'd0;
            lag_b <= 4'd0;
        end else begin
            lag_a <= rom_addr1;
            lag_b <= lag_a;
        end
    end
    assign rom_data1 = 10'h3C0 | {6'b0, lag_b};
    rom_sequencer #(.ADDR_W(4), .DATA_W(10), .DEPTH(10), .WAIT_CYC(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1),
        .done(done1), .rom_addr(rom_addr1), .rom_data(rom_data1), .out(if1));

    // Instance 2: DEPTH=1
    logic       start2 = 1'b0, abort2 = 1'b0, busy2, done2;
    logic [3:0] rom_addr2;
    logic [9:0] rom_data2;
    rom_sequencer_if #(.DATA_W(10)) if2 ();
    assign rom_data2 = 10'h3C0 | {6'b0, rom_addr2};
    rom_sequencer #(.ADDR_W(4), .DATA_W(10), .DEPTH(1), .WAIT_CYC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .busy(busy2),
        .done(done2), .rom_addr(rom_addr2), .rom_data(rom_data2), .out(if2));

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] beats0[$];
    logic [9:0] beats1[$];
    int done_cnt0 = 0;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ready;
        logic [17:0] exp;
    } vec_t;
    vec_t tbl[22];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // {valid, last, done, busy, addr[3:0], data[9:0]}
    function automatic logic [17:0] mk(input logic v, l, d, b, input logic [3:0] a,
                                       input logic [9:0] dt);
        return {v, l, d, b, a, dt};
    endfunction

    function automatic logic [17:0] obs0();
        return {if0.out_valid, if0.out_last, done0, busy0, rom_addr0, if0.out_data};
    endfunction

    task automatic step0(input logic s, input logic a, input logic r);
        start0 = s;
        abort0 = a;
        if0.out_ready = r;
        if (if0.out_valid && r && !a) beats0.push_back(if0.out_data);
        @(posedge clk);
        #1;
        if (done0) done_cnt0++;
    endtask

    task automatic run0_to_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step0(1'b0, 1'b0, 1'b1);
            if (done0) break;
        end
        check("run0_done_reached", {31'b0, done0}, 32'd1);
    endtask

    task automatic check_beats0(input string nm, input int exp_n);
        check({nm, "_count"}, beats0.size(), exp_n);
        for (int i = 0; i < beats0.size() && i < exp_n; i++)
            check($sformatf("%s_beat%0d", nm, i), {22'b0, beats0[i]}, 32'h3C0 | i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Basic sweep table: beat k valid after E(2k+1), accepted at E(2k+2)
        for (int n = 0; n < 22; n++) begin
            tbl[n].start = (n == 0);
            tbl[n].abort = 1'b0;
            tbl[n].ready = 1'b1;
            if (n == 0)
                tbl[n].exp = mk(0, 0, 0, 1, 4'd0, 10'h000);
            else if (n == 21)
                tbl[n].exp = mk(0, 0, 0, 0, 4'd9, 10'h3C9);
            else if (n == 20)
                tbl[n].exp = mk(0, 0, 1, 1, 4'd9, 10'h3C9);
            else if (n % 2 == 1)
                tbl[n].exp = mk(1, (n == 19), 0, 1, 4'((n - 1) / 2), 10'h3C0 | 10'((n - 1) / 2));
            else
                tbl[n].exp = mk(0, 0, 0, 1, 4'(n / 2), 10'h3C0 | 10'(n / 2 - 1));
        end

        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;

        // Reset state
        #12;
        check("reset_u0", {14'b0, obs0()}, 32'd0);
        check("reset_u1", {28'b0, if1.out_valid, done1, busy1, 1'b0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 22; n++) begin
            step0(tbl[n].start, tbl[n].abort, tbl[n].ready);
            check($sformatf("sweep_E%0d", n), {14'b0, obs0()}, {14'b0, tbl[n].exp});
        end
        check_beats0("sweep", 10);
        check("sweep_done_pulses", done_cnt0, 1);

        // Backpressure on beat 3 plus ignored start pulses mid-run
        beats0.delete();
        done_cnt0 = 0;
        for (int n = 0; n < 13; n++) begin
            step0((n == 0) || (n == 5), 1'b0, !(n >= 8));
            if (n >= 8)
                check($sformatf("bp_hold_E%0d", n),
                      {17'b0, if0.out_valid, rom_addr0, if0.out_data}, {17'b0, 1'b1, 4'd3, 10'h3C3});
        end
        step0(1'b1, 1'b0, 1'b1);
        check("bp_release_addr", {28'b0, rom_addr0}, 32'd4);
        run0_to_done(60);
        check_beats0("bp", 10);
        check("bp_done_pulses", done_cnt0, 1);
        step0(1'b0, 1'b0, 1'b1);
        check("bp_busy_after", {31'b0, busy0}, 32'd0);

        // Abort during SEND of beat 5 with ready on the same edge
        beats0.delete();
        done_cnt0 = 0;
        for (int n = 0; n < 12; n++) step0(n == 0, 1'b0, 1'b1);
        check("abort_pre", {14'b0, obs0()}, {14'b0, mk(1, 0, 0, 1, 4'd5, 10'h3C5)});
        step0(1'b0, 1'b1, 1'b1);
        check("abort_post", {14'b0, obs0()}, {14'b0, mk(0, 0, 0, 0, 4'd0, 10'h3C5)});
        check_beats0("abort", 5);
        for (int n = 0; n < 3; n++) step0(1'b0, 1'b0, 1'b1);
        check("abort_no_done", done_cnt0, 0);
        check("abort_idle", {31'b0, busy0}, 32'd0);
        beats0.delete();
        step0(1'b1, 1'b0, 1'b1);
        step0(1'b0, 1'b0, 1'b1);
        check("restart_first", {14'b0, obs0()}, {14'b0, mk(1, 0, 0, 1, 4'd0, 10'h3C0)});
        run0_to_done(60);
        check_beats0("restart", 10);
        check("restart_done_pulses", done_cnt0, 1);
        step0(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-run
        step0(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 6; n++) step0(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {14'b0, obs0()}, 32'd0);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 3; n++) step0(1'b0, 1'b0, 1'b1);
        check("reset_no_resume", {14'b0, obs0()}, 32'd0);

        // Settle time: WAIT_CYC=3 with a lagging ROM
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("settle_not_yet_E2", {31'b0, if1.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("settle_first_E3", {21'b0, if1.out_valid, if1.out_data}, {21'b0, 1'b1, 10'h3C0});
        if1.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (if1.out_valid) beats1.push_back(if1.out_data);
            @(posedge clk);
            #1;
            if (done1) break;
        end
        check("settle_done", {31'b0, done1}, 32'd1);
        check("settle_count", beats1.size(), 10);
        for (int i = 0; i < beats1.size() && i < 10; i++)
            check($sformatf("settle_beat%0d", i), {22'b0, beats1[i]}, 32'h3C0 | i);
        if1.out_ready = 1'b0;

        // DEPTH=1
        if2.out_ready = 1'b1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        @(posedge clk);
        #1;
        check("d1_beat", {20'b0, if2.out_valid, if2.out_last, if2.out_data}, {20'b0, 2'b11, 10'h3C0});
        @(posedge clk);
        #1;
        check("d1_done", {29'b0, done2, if2.out_valid, busy2}, {29'b0, 3'b101});
        @(posedge clk);
        #1;
        check("d1_idle", {30'b0, done2, busy2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
